// File: rtl/filter_ctrl_if.sv
// rtl/filter_ctrl_if.sv - kernel-config and image-stream sideband signals of filter_ctrl
interface filter_ctrl_if #(
    parameter int KER_WIDTH = 16,
    parameter int KER_NUM   = 9
);
    logic [KER_WIDTH-1:0] cfg_data;
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [KER_WIDTH-1:0] ker_data;
    logic [KER_NUM-1:0]   ker_val;
    logic                 ker_loaded;
    logic                 up_val;
    logic                 up_last;
    logic                 up_rdy;
    logic                 dn_val;
    logic                 dn_last;

    modport master (
        output cfg_data, cfg_valid, up_val, up_last,
        input  cfg_ready, ker_data, ker_val, ker_loaded, up_rdy, dn_val, dn_last
    );

    modport slave (
        input  cfg_data, cfg_valid, up_val, up_last,
        output cfg_ready, ker_data, ker_val, ker_loaded, up_rdy, dn_val, dn_last
    );
endinterface

// File: rtl/filter_ctrl.sv
// rtl/filter_ctrl.sv - tap-chain sequencer: coefficient loading, stream gating, valid/last delay lines
module filter_ctrl #(
    parameter int KER_WIDTH = 16,
    parameter int KER_NUM   = 9,
    parameter int KER_LAT   = 3,
    parameter int PIPE_LAT  = 12
) (
    input  logic          clk,
    input  logic          rst,
    filter_ctrl_if.slave  bus
);
    localparam int IDX_W = (KER_NUM > 1) ? $clog2(KER_NUM) : 1;
    localparam int SET_W = (KER_LAT > 0) ? $clog2(KER_LAT + 1) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, RUN, DRAIN} state_t;

    state_t               state;
    logic [IDX_W-1:0]     idx;
    logic [SET_W-1:0]     settle_cnt;
    logic [KER_WIDTH-1:0] ker_data_q;
    logic [KER_NUM-1:0]   ker_val_q;
    logic                 ker_loaded_q;
    logic                 cfg_ready_q;
    logic                 run_q;
    logic [PIPE_LAT-1:0]  val_line;
    logic [PIPE_LAT-1:0]  last_line;
    logic                 accept;
    logic                 settle_done;

    // A pending kernel always wins over image input, so up_rdy is cut in the same cycle.
    assign bus.up_rdy     = run_q & ~bus.cfg_valid;
    assign accept         = bus.up_val & bus.up_rdy;
    assign settle_done    = (KER_LAT <= 1) || (settle_cnt == SET_W'(KER_LAT - 1));

    assign bus.cfg_ready  = cfg_ready_q;
    assign bus.ker_data   = ker_data_q;
    assign bus.ker_val    = ker_val_q;
    assign bus.ker_loaded = ker_loaded_q;
    assign bus.dn_val     = val_line[PIPE_LAT-1];
    assign bus.dn_last    = last_line[PIPE_LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            settle_cnt   <= '0;
            ker_data_q   <= '0;
            ker_val_q    <= '0;
            ker_loaded_q <= 1'b0;
            cfg_ready_q  <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            ker_val_q <= '0;
            case (state)
                IDLE: begin
                    if (bus.cfg_valid) begin
                        state       <= LOAD;
                        cfg_ready_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.cfg_valid) begin
                        ker_data_q <= bus.cfg_data;
                        ker_val_q  <= KER_NUM'(1) << idx;
                        if (idx == IDX_W'(KER_NUM - 1)) begin
                            idx         <= '0;
                            state       <= SETTLE;
                            cfg_ready_q <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_done) begin
                        settle_cnt   <= '0;
                        state        <= RUN;
                        ker_loaded_q <= 1'b1;
                        run_q        <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (bus.cfg_valid) begin
                        state        <= DRAIN;
                        ker_loaded_q <= 1'b0;
                        run_q        <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (~|val_line) begin
                        state       <= LOAD;
                        cfg_ready_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sideband lines mirror the datapath latency; they run in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            val_line  <= '0;
            last_line <= '0;
        end else begin
            val_line  <= (val_line << 1) | PIPE_LAT'(accept);
            last_line <= (last_line << 1) | PIPE_LAT'(accept & bus.up_last);
        end
    end
endmodule

// File: tb/tb_filter_ctrl.sv
// tb/tb_filter_ctrl.sv - scoreboard bench for filter_ctrl (main config and KER_NUM=1/PIPE_LAT=1 edge config)
module tb_filter_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   m_idx = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    filter_ctrl_if #(.KER_WIDTH(16), .KER_NUM(3)) b0();
    filter_ctrl_if #(.KER_WIDTH(16), .KER_NUM(1)) b1();

    filter_ctrl #(.KER_WIDTH(16), .KER_NUM(3), .KER_LAT(3), .PIPE_LAT(12)) u0 (.clk(clk), .rst(rst), .bus(b0));
    filter_ctrl #(.KER_WIDTH(16), .KER_NUM(1), .KER_LAT(3), .PIPE_LAT(1))  u1 (.clk(clk), .rst(rst), .bus(b1));

    typedef struct { int due; logic [2:0] val; logic [15:0] data; } kexp_t;
    typedef struct { int due; logic last; } dexp_t;
    kexp_t kq[$];
    dexp_t dq0[$];
    dexp_t dq1[$];

    // Monitor: compare due items first, then record this cycle's handshakes.
    always @(negedge clk) begin
        if (kq.size() > 0 && kq[0].due == cyc) begin
            total++;
            if (b0.ker_val !== kq[0].val || b0.ker_data !== kq[0].data) begin
                bad++;
                $display("FAIL ker_load cyc=%0d got val=%b data=%h want val=%b data=%h",
                         cyc, b0.ker_val, b0.ker_data, kq[0].val, kq[0].data);
            end
            kq.delete(0);
        end else begin
            total++;
            if (b0.ker_val !== 3'b000) begin
                bad++;
                $display("FAIL ker_val_idle cyc=%0d got %b want 000", cyc, b0.ker_val);
            end
        end
        if (dq0.size() > 0 && dq0[0].due == cyc) begin
            total++;
            if (b0.dn_val !== 1'b1 || b0.dn_last !== dq0[0].last) begin
                bad++;
                $display("FAIL dn0 cyc=%0d got val=%b last=%b want val=1 last=%b", cyc, b0.dn_val, b0.dn_last, dq0[0].last);
            end
            dq0.delete(0);
        end else begin
            total++;
            if (b0.dn_val !== 1'b0 || b0.dn_last !== 1'b0) begin
                bad++;
                $display("FAIL dn0_idle cyc=%0d got val=%b last=%b want 0 0", cyc, b0.dn_val, b0.dn_last);
            end
        end
        if (dq1.size() > 0 && dq1[0].due == cyc) begin
            total++;
            if (b1.dn_val !== 1'b1 || b1.dn_last !== dq1[0].last) begin
                bad++;
                $display("FAIL dn1 cyc=%0d got val=%b last=%b want val=1 last=%b", cyc, b1.dn_val, b1.dn_last, dq1[0].last);
            end
            dq1.delete(0);
        end else begin
            total++;
            if (b1.dn_val !== 1'b0 || b1.dn_last !== 1'b0) begin
                bad++;
                $display("FAIL dn1_idle cyc=%0d got val=%b last=%b want 0 0", cyc, b1.dn_val, b1.dn_last);
            end
        end
        if (rst) begin
            kq.delete();
            dq0.delete();
            dq1.delete();
            m_idx = 0;
        end else begin
            if (b0.cfg_valid && b0.cfg_ready) begin
                kq.push_back(kexp_t'{due: cyc + 1, val: 3'(1 << m_idx), data: b0.cfg_data});
                m_idx = (m_idx == 2) ? 0 : m_idx + 1;
            end
            if (b0.up_val && b0.up_rdy) dq0.push_back(dexp_t'{due: cyc + 12, last: b0.up_last});
            if (b1.up_val && b1.up_rdy) dq1.push_back(dexp_t'{due: cyc + 1, last: b1.up_last});
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        b0.cfg_valid = 1'b0; b0.cfg_data = '0; b0.up_val = 1'b0; b0.up_last = 1'b0;
        b1.cfg_valid = 1'b0; b1.cfg_data = '0; b1.up_val = 1'b0; b1.up_last = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic cfg_word0(input logic [15:0] d);
        int n = 0;
        b0.cfg_valid = 1'b1;
        b0.cfg_data  = d;
        while (b0.cfg_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (n >= 50) begin
            bad++;
            $display("FAIL cfg0_timeout got cfg_ready=%b want 1 within 50 cycles", b0.cfg_ready);
        end
        tick();
        b0.cfg_valid = 1'b0;
    endtask

    task automatic wait_loaded0(input int kv);
        int n = 0;
        while (b0.ker_loaded !== 1'b1 && n < 20) begin
            total++;
            if (b0.up_rdy !== 1'b0) begin
                bad++;
                $display("FAIL early_up_rdy cyc=%0d got %b want 0", cyc, b0.up_rdy);
            end
            tick();
            n++;
        end
        total++;
        if (b0.ker_loaded !== 1'b1 || b0.up_rdy !== 1'b1 || cyc != kv + 3) begin
            bad++;
            $display("FAIL settle0 got loaded=%b up_rdy=%b cyc=%0d want 1 1 cyc=%0d",
                     b0.ker_loaded, b0.up_rdy, cyc, kv + 3);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({b0.cfg_ready, b0.ker_val, b0.ker_data, b0.ker_loaded, b0.up_rdy, b0.dn_val, b0.dn_last} !== '0) begin
            bad++;
            $display("FAIL reset0 got rdy=%b kv=%b kd=%h ld=%b ur=%b dv=%b dl=%b want all 0",
                     b0.cfg_ready, b0.ker_val, b0.ker_data, b0.ker_loaded, b0.up_rdy, b0.dn_val, b0.dn_last);
        end
        total++;
        if ({b1.cfg_ready, b1.ker_val, b1.ker_data, b1.ker_loaded, b1.up_rdy, b1.dn_val, b1.dn_last} !== '0) begin
            bad++;
            $display("FAIL reset1 got rdy=%b kv=%b kd=%h ld=%b want all 0", b1.cfg_ready, b1.ker_val, b1.ker_data, b1.ker_loaded);
        end
    endtask

    task automatic test_back_to_back();
        cfg_word0(16'd5);
        cfg_word0(16'hFFFE);
        cfg_word0(16'd7);
        wait_loaded0(cyc);
    endtask

    task automatic test_gapped();
        do_reset();
        cfg_word0(16'd1);
        tick(2);
        cfg_word0(16'd2);
        tick(2);
        cfg_word0(16'd3);
        wait_loaded0(cyc);
    endtask

    task automatic test_latency();
        int a0 = 0;
        for (int i = 0; i < 4; i++) begin
            b0.up_val  = 1'b1;
            b0.up_last = (i == 3);
            if (i == 0) a0 = cyc;
            #1;
            total++;
            if (b0.up_rdy !== 1'b1) begin
                bad++;
                $display("FAIL run_up_rdy i=%0d got %b want 1", i, b0.up_rdy);
            end
            tick();
        end
        b0.up_val  = 1'b0;
        b0.up_last = 1'b0;
        while (cyc < a0 + 12) tick();
        total++;
        if (b0.dn_val !== 1'b1 || b0.dn_last !== 1'b0) begin
            bad++;
            $display("FAIL lat_first got val=%b last=%b want 1 0", b0.dn_val, b0.dn_last);
        end
        tick(3);
        total++;
        if (b0.dn_val !== 1'b1 || b0.dn_last !== 1'b1) begin
            bad++;
            $display("FAIL lat_last got val=%b last=%b want 1 1", b0.dn_val, b0.dn_last);
        end
        tick();
        total++;
        if (b0.dn_val !== 1'b0) begin
            bad++;
            $display("FAIL lat_end got val=%b want 0", b0.dn_val);
        end
    endtask

    task automatic test_reload();
        int a2 = 0;
        int n = 0;
        b0.up_val  = 1'b1;
        b0.up_last = 1'b0;
        tick(2);
        a2 = cyc;
        tick();
        b0.cfg_valid = 1'b1;
        b0.cfg_data  = 16'd11;
        #1;
        total++;
        if (b0.up_rdy !== 1'b0) begin
            bad++;
            $display("FAIL reload_priority got up_rdy=%b want 0", b0.up_rdy);
        end
        while (b0.cfg_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (b0.cfg_ready !== 1'b1 || cyc != a2 + 14) begin
            bad++;
            $display("FAIL reload_load_entry got cfg_ready=%b cyc=%0d want 1 cyc=%0d", b0.cfg_ready, cyc, a2 + 14);
        end
        tick();
        b0.cfg_valid = 1'b0;
        cfg_word0(16'd12);
        cfg_word0(16'd13);
        wait_loaded0(cyc);
        b0.up_val = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        cfg_word0(16'd21);
        cfg_word0(16'd22);
        rst = 1'b1;
        tick();
        total++;
        if ({b0.cfg_ready, b0.ker_val, b0.ker_data, b0.ker_loaded, b0.up_rdy, b0.dn_val, b0.dn_last} !== '0) begin
            bad++;
            $display("FAIL midload_reset got rdy=%b kv=%b kd=%h ld=%b ur=%b dv=%b want all 0",
                     b0.cfg_ready, b0.ker_val, b0.ker_data, b0.ker_loaded, b0.up_rdy, b0.dn_val);
        end
        rst = 1'b0;
        cfg_word0(16'd31);
        total++;
        if (b0.ker_val !== 3'b001) begin
            bad++;
            $display("FAIL midload_restart got ker_val=%b want 001", b0.ker_val);
        end
        cfg_word0(16'd32);
        cfg_word0(16'd33);
        wait_loaded0(cyc);
    endtask

    task automatic test_edge();
        int kv = 0;
        int n = 0;
        b1.cfg_valid = 1'b1;
        b1.cfg_data  = 16'h00A5;
        while (b1.cfg_ready !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        tick();
        b1.cfg_valid = 1'b0;
        kv = cyc;
        total++;
        if (b1.ker_val !== 1'b1 || b1.ker_data !== 16'h00A5) begin
            bad++;
            $display("FAIL edge_load got val=%b data=%h want 1 00a5", b1.ker_val, b1.ker_data);
        end
        n = 0;
        while (b1.ker_loaded !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (b1.ker_loaded !== 1'b1 || cyc != kv + 3) begin
            bad++;
            $display("FAIL edge_settle got loaded=%b cyc=%0d want 1 cyc=%0d", b1.ker_loaded, cyc, kv + 3);
        end
        b1.up_val  = 1'b1;
        b1.up_last = 1'b1;
        tick();
        b1.up_val  = 1'b0;
        b1.up_last = 1'b0;
        total++;
        if (b1.dn_val !== 1'b1 || b1.dn_last !== 1'b1) begin
            bad++;
            $display("FAIL edge_lat got val=%b last=%b want 1 1", b1.dn_val, b1.dn_last);
        end
        tick();
        b1.cfg_valid = 1'b1;
        b1.cfg_data  = 16'h005A;
        #1;
        total++;
        if (b1.up_rdy !== 1'b0) begin
            bad++;
            $display("FAIL edge_priority got up_rdy=%b want 0", b1.up_rdy);
        end
        tick();
        total++;
        if (b1.cfg_ready !== 1'b0) begin
            bad++;
            $display("FAIL edge_drain got cfg_ready=%b want 0", b1.cfg_ready);
        end
        tick();
        total++;
        if (b1.cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL edge_drain_len got cfg_ready=%b want 1", b1.cfg_ready);
        end
        tick();
        b1.cfg_valid = 1'b0;
        total++;
        if (b1.ker_val !== 1'b1 || b1.ker_data !== 16'h005A) begin
            bad++;
            $display("FAIL edge_reload got val=%b data=%h want 1 005a", b1.ker_val, b1.ker_data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_latency();
        test_reload();
        test_reset_mid_load();
        test_gapped();
        test_edge();
        tick(16);
        total++;
        if (kq.size() != 0 || dq0.size() != 0 || dq1.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got %0d/%0d/%0d entries want 0/0/0", kq.size(), dq0.size(), dq1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
